// File: rtl/seg7_scan_mux.sv
// ============================================================================
// seg7_scan_mux : time-multiplexed common-anode 7-segment scan driver with
//                 per-digit blink and a per-frame snapshot. Optional macro
//                 SEG7_LZB_EN blanks a zero in the top digit.
// Revision 1.0
// ============================================================================
`default_nettype none

module seg7_scan_mux #(
   parameter int NUM_DIGITS   = 6,
   parameter int SCAN_DIV     = 50000,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [4*NUM_DIGITS-1:0]   digits_in,
   input  logic [NUM_DIGITS-1:0]     blink_mask,
   input  logic                      scan_en,
   output logic [3:0]                hex_out,
   output logic [NUM_DIGITS-1:0]     digit_sel_n,
   output logic                      frame_tick
);

   localparam int c_PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int c_BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(SCAN_DIV - 1);
   localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NUM_DIGITS - 1);
   localparam logic [c_BLK_W-1:0] c_BLK_LAST = c_BLK_W'(BLINK_FRAMES - 1);

   logic [c_PRE_W-1:0]        pre_q;
   logic [c_IDX_W-1:0]        idx_q;
   logic [c_BLK_W-1:0]        blink_cnt_q;
   logic                      blink_ph_q;
   logic [4*NUM_DIGITS-1:0]   snap_q;
   logic [4*NUM_DIGITS-1:0]   snap_d;

   logic                      w_pre_last;
   logic                      w_frame_wrap;
   logic [3:0]                w_code;
   logic                      w_mask_bit;
   logic [NUM_DIGITS-1:0]     w_sel_n;
   logic [3:0]                w_hex;

   assign w_pre_last   = (pre_q == c_PRE_LAST);
   assign w_frame_wrap = w_pre_last && (idx_q == c_IDX_LAST);

   // The snapshot is taken only at the very start of a frame so one frame never mixes inputs.
   assign snap_d = ((pre_q == '0) && (idx_q == '0)) ? digits_in : snap_q;

   always_comb begin
      w_code     = 4'hF;
      w_mask_bit = 1'b0;
      w_sel_n    = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == c_IDX_W'(i)) begin
            w_code     = snap_d[4*i +: 4];
            w_mask_bit = blink_mask[i];
            w_sel_n[i] = 1'b0;
         end
      end
   end

`ifdef SEG7_LZB_EN
   logic [3:0] w_code_lz;
   assign w_code_lz = ((idx_q == c_IDX_LAST) && (snap_d[4*NUM_DIGITS-1 -: 4] == 4'h0))
                      ? 4'hF : w_code;
   assign w_hex     = (blink_ph_q && w_mask_bit) ? 4'hF : w_code_lz;
`else
   assign w_hex     = (blink_ph_q && w_mask_bit) ? 4'hF : w_code;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         pre_q       <= '0;
         idx_q       <= '0;
         blink_cnt_q <= '0;
         blink_ph_q  <= 1'b0;
         snap_q      <= '1;
         hex_out     <= 4'hF;
         digit_sel_n <= '1;
         frame_tick  <= 1'b0;
      end else if (scan_en) begin
         snap_q      <= snap_d;
         hex_out     <= w_hex;
         digit_sel_n <= w_sel_n;
         frame_tick  <= w_frame_wrap;
         if (w_pre_last) begin
            pre_q <= '0;
            idx_q <= (idx_q == c_IDX_LAST) ? '0 : idx_q + c_IDX_W'(1);
         end else begin
            pre_q <= pre_q + c_PRE_W'(1);
         end
         if (w_frame_wrap) begin
            if (blink_cnt_q == c_BLK_LAST) begin
               blink_cnt_q <= '0;
               blink_ph_q  <= ~blink_ph_q;
            end else begin
               blink_cnt_q <= blink_cnt_q + c_BLK_W'(1);
            end
         end
      end else begin
         // Disabled: display dark, all scan state frozen in place.
         hex_out     <= 4'hF;
         digit_sel_n <= '1;
         frame_tick  <= 1'b0;
      end
   end

endmodule

`default_nettype wire
